deserializer_sipo: RTL

DESERIALIZER_SIPO -- requirements
Module: deserializer_sipo

---
 rtl/deserializer_pkg.sv | 10 +
 rtl/sipo_shift_reg.sv | 40 ++++
 rtl/deserializer_sipo.sv | 113 +++++++++++
 3 files changed

// File: rtl/deserializer_pkg.sv
// deserializer_pkg: shared types and constants for the SIPO deserializer.
//   state_t        - receive FSM state (IDLE / SHIFT)
//   DATA_WIDTH_DEF - default parallel word width
//   CNT_W          - bit-counter width; covers a 32-bit word plus a parity bit
package deserializer_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int CNT_W          = 6;
endpackage

// File: rtl/sipo_shift_reg.sv
// sipo_shift_reg: MSB-first shift register plus bit counter for one frame.
//   clk, rst_n : clock, async active-low reset
//   i_start    : sample i_bit as the first bit of a new frame (count -> 1)
//   i_adv      : sample i_bit as a continuation bit
//   i_bit      : serial data bit
//   o_word     : frame bits received so far, latest bit in the LSB
//   o_last     : i_adv is sampling the final bit of the frame
module sipo_shift_reg
  import deserializer_pkg::*;
#(
  parameter int FRAME_LEN = DATA_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic                 i_adv,
  input  logic                 i_bit,
  output logic [FRAME_LEN-1:0] o_word,
  output logic                 o_last
);
  logic [FRAME_LEN-1:0] r_sreg;
  logic [CNT_W-1:0]     r_cnt;

  assign o_word = r_sreg;
  assign o_last = i_adv && (r_cnt == CNT_W'(FRAME_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else if (i_start) begin
      // a restart throws away whatever partial word was held
      r_sreg <= FRAME_LEN'(i_bit);
      r_cnt  <= CNT_W'(1);
    end else if (i_adv) begin
      r_sreg <= {r_sreg[FRAME_LEN-2:0], i_bit};
      r_cnt  <= o_last ? '0 : r_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/deserializer_sipo.sv
// deserializer_sipo: serial-in / parallel-out deserializer with a one-word
// output buffer, valid/ready handshake and a sticky overrun flag.
// Optional feature macro PARITY_CHECK_EN: each frame carries one trailing
// even-parity bit; parity_err reports its check alongside data_out.
//   clk, rst_n  : clock, async active-low reset
//   srl_in      : serial data, sampled when shift=1
//   shift       : bit strobe
//   frame_start : sampled bit is the MSB of a new frame
//   out_ready   : consumer takes data_out
//   clr_ovr     : clear overrun
//   data_out    : assembled word        out_valid : data_out unconsumed
//   busy        : frame in progress     overrun   : sticky dropped-word flag
//   parity_err  : parity status of data_out (0 without PARITY_CHECK_EN)
module deserializer_sipo
  import deserializer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  srl_in,
  input  logic                  shift,
  input  logic                  frame_start,
  input  logic                  out_ready,
  input  logic                  clr_ovr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  overrun,
  output logic                  parity_err
);
`ifdef PARITY_CHECK_EN
  localparam int FRAME_LEN = DATA_WIDTH + 1;
`else
  localparam int FRAME_LEN = DATA_WIDTH;
`endif

  state_t                r_state;
  logic                  r_done;   // frame completed on the previous edge
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_ovr;

  logic                 w_start;
  logic                 w_adv;
  logic                 w_last;
  logic [FRAME_LEN-1:0] w_word;
  logic [DATA_WIDTH-1:0] w_data;

  assign w_start = shift && frame_start;
  assign w_adv   = shift && !frame_start && (r_state == SHIFT);

  sipo_shift_reg #(.FRAME_LEN(FRAME_LEN)) u_sreg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_adv   (w_adv),
    .i_bit   (srl_in),
    .o_word  (w_word),
    .o_last  (w_last)
  );

`ifdef PARITY_CHECK_EN
  logic r_perr;
  logic w_perr;
  assign w_data     = w_word[FRAME_LEN-1:1];
  assign w_perr     = ^w_word;  // data bits XOR parity bit
  assign parity_err = r_perr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_perr <= 1'b0;
    else if (r_done && (!r_valid || out_ready))
      r_perr <= w_perr;
  end
`else
  assign w_data     = w_word;
  assign parity_err = 1'b0;
`endif

  // The completed word sits in the shift register for the cycle after its
  // last bit; a restart on that edge only changes the register afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_done <= w_last;

      if (w_start)     r_state <= SHIFT;
      else if (w_last) r_state <= IDLE;

      if (r_done && (!r_valid || out_ready)) begin
        r_data  <= w_data;
        r_valid <= 1'b1;
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end

      // a new drop wins over a simultaneous clear
      if (r_done && r_valid && !out_ready) r_ovr <= 1'b1;
      else if (clr_ovr)                    r_ovr <= 1'b0;
    end
  end

  assign data_out  = r_data;
  assign out_valid = r_valid;
  assign busy      = (r_state == SHIFT);
  assign overrun   = r_ovr;
endmodule
